// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 serial command receiver with a 2-flop input synchronizer,
// mid-bit sampling, good-byte and frame-error strobes, and break tolerance.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit after bit 7).
module uart_cmd_rx #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rxdata,
   output logic       dataValidRX,
   output logic       frameErr,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int TW           = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} RxState;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} RxState;
`endif

   RxState          state;
   RxState          stateNext;
   logic            rxMeta;
   logic            rxS;
   logic [TW-1:0]   bitTimer;
   logic [2:0]      bitCnt;
   logic [7:0]      shiftReg;
   logic            timerClr;
   logic            shiftEn;
   logic            loadData;
   logic            errPulse;
`ifdef UART_PARITY_EN
   logic            parityCapture;
   logic            parityErr;
`endif

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxS    <= rxMeta;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // Next-state decode plus the per-cycle datapath controls.
   always_comb begin
      stateNext = state;
      timerClr  = 1'b0;
      shiftEn   = 1'b0;
      loadData  = 1'b0;
      errPulse  = 1'b0;
`ifdef UART_PARITY_EN
      parityCapture = 1'b0;
`endif
      case (state)
         IDLE: begin
            timerClr = 1'b1;
            if (!rxS) stateNext = START;
         end
         START: begin
            if (bitTimer == HALF_END) stateNext = rxS ? IDLE : DATA;
         end
         DATA: begin
            if (bitTimer == BIT_END) begin
               shiftEn  = 1'b1;
               timerClr = 1'b1;
`ifdef UART_PARITY_EN
               if (bitCnt == 3'd7) stateNext = PARITY;
`else
               if (bitCnt == 3'd7) stateNext = STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (bitTimer == BIT_END) begin
               parityCapture = 1'b1;
               stateNext     = STOP;
            end
         end
`endif
         STOP: begin
            if (bitTimer == BIT_END) begin
               if (rxS) begin
                  stateNext = IDLE;
`ifdef UART_PARITY_EN
                  if (parityErr) errPulse = 1'b1;
                  else           loadData = 1'b1;
`else
                  loadData = 1'b1;
`endif
               end else begin
                  errPulse  = 1'b1;
                  stateNext = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            timerClr = 1'b1;
            if (rxS) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Bit timer restarts on every state change and after each data sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              bitTimer <= '0;
      else if (timerClr || stateNext != state) bitTimer <= '0;
      else                                     bitTimer <= bitTimer + TW'(1);
   end

   // Data bit counter and LSB-first shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitCnt   <= 3'd0;
         shiftReg <= 8'h00;
      end else begin
         if (state != DATA)  bitCnt <= 3'd0;
         else if (shiftEn)   bitCnt <= bitCnt + 3'd1;
         if (shiftEn)        shiftReg <= {rxS, shiftReg[7:1]};
      end
   end

`ifdef UART_PARITY_EN
   // Even parity: the parity bit must equal the XOR of the eight data bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             parityErr <= 1'b0;
      else if (parityCapture) parityErr <= rxS ^ (^shiftReg);
   end
`endif

   // Output register: byte capture and one-cycle strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxdata      <= 8'h00;
         dataValidRX <= 1'b0;
         frameErr    <= 1'b0;
      end else begin
         dataValidRX <= loadData;
         frameErr    <= errPulse;
         if (loadData) rxdata <= shiftReg;
      end
   end

   assign busy = (state != IDLE);

endmodule
